conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter MATRIX_SIZE, default 3, window edge length; only 3 is supported.
REQ-003 SHALL have parameter IMG_COLS, default 64, pixels per row (minimum 3).
REQ-004 SHALL have parameter IMG_ROWS, default 64, rows per frame (minimum 3).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_pixel, input, IMAGE_WIDTH, raster-order unsigned pixel.
REQ-008 SHALL have port in_valid, input, 1, in_pixel is valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts in_pixel this cycle.
REQ-010 SHALL have port out_matrix, output, IMAGE_WIDTH*MATRIX_SIZE**2, flattened window; element k=r*3+c at bits [k*IMAGE_WIDTH +: IMAGE_WIDTH], r=0 top row, c=0 leftmost column.
REQ-011 SHALL have port out_valid, output, 1, out_matrix holds a complete window.
REQ-012 SHALL have port out_ready, input, 1, downstream convolution stage consumes the window.
REQ-013 SHALL have port frame_done, output, 1, single-cycle pulse on the last window of a frame.

Function
REQ-014 SHALL accept a pixel on in_valid && in_ready; no other cycle changes internal state except the output handshake.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (one-deep output register, no bubble under continuous flow).
REQ-016 SHALL track col (0..IMG_COLS-1) and row (0..IMG_ROWS-1) of the next accepted pixel; col wraps to 0 and row increments at IMG_COLS-1; both wrap to 0 after (IMG_ROWS-1, IMG_COLS-1).
REQ-017 SHALL keep MATRIX_SIZE-1 row delay lines and a 3x3 shift window; each accepted pixel shifts the window left by one column and loads the new right column {line2, line1, in_pixel} (top to bottom).
REQ-018 SHALL emit windows only for valid positions with no padding: accepted pixel with row>=2 and col>=2; window centre is (row-1, col-1); (IMG_ROWS-2)*(IMG_COLS-2) windows per frame.
REQ-019 SHALL register out_matrix and assert out_valid on the cycle after the accepting edge (latency 1); out_valid and out_matrix SHALL hold stable until out_valid && out_ready.
REQ-020 SHALL, when out_ready and a new qualifying pixel are accepted in the same cycle, replace the window with no idle cycle.
REQ-021 SHALL assert frame_done for exactly one cycle, coincident with the first out_valid cycle of the window for pixel (IMG_ROWS-1, IMG_COLS-1).
REQ-022 SHALL treat pixels at col<2 or row<2 as fill-only: they update delay lines and window, with no output.
REQ-023 SHALL process back-to-back frames with no gap; windows never straddle rows or frames.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-frame, clear col, row, out_valid, frame_done and out_matrix to 0 immediately; in_ready SHALL read 1 after reset.
REQ-025 SHALL NOT require reset of delay-line storage; stale contents SHALL never reach out_matrix, since the first qualifying window follows two full fill rows.

Configuration
REQ-026 SHALL, with macro CONV_WINDOW_SOF_EN defined, add input in_sof (1 bit); an accepted pixel with in_sof=1 is treated as (row 0, col 0) and the counters restart from it.
REQ-027 SHALL, without CONV_WINDOW_SOF_EN, omit in_sof and rely solely on the free-running counters from reset.

Structure
REQ-028 SHALL place IMAGE_WIDTH and MATRIX_SIZE defaults, the window-index localparam/function (r*MATRIX_SIZE+c), and the window packed type in shared package conv_pkg, also used by the convolution stage.
REQ-029 SHALL implement each row delay as sub-module line_buffer (IMG_COLS deep, IMAGE_WIDTH wide, advance-enable input), instantiated MATRIX_SIZE-1 times.

Verification
REQ-030 IMG_COLS=5, IMG_ROWS=4, pixel=r*5+c, continuous flow, out_ready=1 -> first out_valid one cycle after pixel 12 accepted, elements k0..k8 = 0,1,2,5,6,7,10,11,12.
REQ-031 Same frame -> exactly 6 windows, bottom-right element values 12,13,14,17,18,19; frame_done only with the window ending at 19.
REQ-032 out_ready held low for 4 cycles while out_valid=1 -> in_ready=0, out_matrix unchanged, no pixel lost; the next window is correct after release.
REQ-033 Two frames back-to-back (second frame pixel=100+r*5+c) -> second-frame first window = 100,101,102,105,106,107,110,111,112; no window mixes frames.
REQ-034 rst_n pulsed low after pixel 8, then a full frame -> outputs 0 during reset, then the exact REQ-030/031 sequence.
REQ-035 With CONV_WINDOW_SOF_EN, 7 junk pixels followed by a frame whose first pixel has in_sof=1 -> output identical to REQ-030/031.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg : shared pixel/window definitions for the window generator and  |
// | convolution stage.                                          Rev 1.0      |
// +--------------------------------------------------------------------------+
package conv_pkg;

   localparam int CONV_IMAGE_WIDTH = 8;
   localparam int CONV_MATRIX_SIZE = 3;
   localparam int CONV_WIN_ELEMS   = CONV_MATRIX_SIZE * CONV_MATRIX_SIZE;

   // Element k = r*MATRIX_SIZE + c, r=0 top row, c=0 leftmost column.
   typedef logic [CONV_WIN_ELEMS-1:0][CONV_IMAGE_WIDTH-1:0] window_t;

   function automatic int win_idx(input int r, input int c, input int msize);
      return r * msize + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_buffer : DEPTH-entry pixel delay line advancing only on en_i.       |
// |                                                             Rev 1.0      |
// +--------------------------------------------------------------------------+
module line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en_i) begin
         ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Circular storage: the slot about to be overwritten holds the pixel from DEPTH advances ago.
   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[ptr_q] <= din_i;
      end
   end

   assign dout_o = mem_q[ptr_q];

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_window_gen : raster pixel stream -> valid-only 3x3 sliding windows. |
// | Optional start-of-frame input via CONV_WINDOW_SOF_EN.       Rev 1.0      |
// +--------------------------------------------------------------------------+
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int IMAGE_WIDTH = CONV_IMAGE_WIDTH,
   parameter int MATRIX_SIZE = CONV_MATRIX_SIZE,
   parameter int IMG_COLS    = 64,
   parameter int IMG_ROWS    = 64
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [IMAGE_WIDTH-1:0]                in_pixel,
   input  logic                                  in_valid,
`ifdef CONV_WINDOW_SOF_EN
   input  logic                                  in_sof,
`endif
   output logic                                  in_ready,
   output logic [IMAGE_WIDTH*MATRIX_SIZE**2-1:0] out_matrix,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  frame_done
);

   localparam int ELEMS = MATRIX_SIZE * MATRIX_SIZE;
   localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
   localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_ROWS - 1);
   localparam logic [COL_W-1:0] FIRST_COL = COL_W'(MATRIX_SIZE - 1);
   localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(MATRIX_SIZE - 1);

   logic                                   accept;
   logic [COL_W-1:0]                       col_q, col_d, pos_col;
   logic [ROW_W-1:0]                       row_q, row_d, pos_row;
   logic                                   win_pos;
   logic                                   last_pos;
   logic [IMAGE_WIDTH-1:0]                 tap [MATRIX_SIZE];
   logic [ELEMS-1:0][IMAGE_WIDTH-1:0]      win_q, win_d;
   logic [ELEMS-1:0][IMAGE_WIDTH-1:0]      out_matrix_q;
   logic                                   out_valid_q;
   logic                                   frame_done_q;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      pos_col = col_q;
      pos_row = row_q;
`ifdef CONV_WINDOW_SOF_EN
      if (in_sof) begin
         pos_col = '0;
         pos_row = '0;
      end
`endif
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (pos_col == LAST_COL) begin
            col_d = '0;
            row_d = (pos_row == LAST_ROW) ? '0 : pos_row + ROW_W'(1);
         end else begin
            col_d = pos_col + COL_W'(1);
            row_d = pos_row;
         end
      end
   end

   // Rows/columns above or left of the first full window only prime the delay lines.
   assign win_pos  = (pos_col >= FIRST_COL) && (pos_row >= FIRST_ROW);
   assign last_pos = (pos_col == LAST_COL) && (pos_row == LAST_ROW);

   assign tap[0] = in_pixel;

   generate
      for (genvar i = 0; i < MATRIX_SIZE - 1; i++) begin : g_line
         line_buffer #(
            .DEPTH (IMG_COLS),
            .WIDTH (IMAGE_WIDTH)
         ) u_line_buffer (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (accept),
            .din_i  (tap[i]),
            .dout_o (tap[i+1])
         );
      end
   endgenerate

   // Shift left one column; the new right column is the oldest line at the top.
   always_comb begin
      win_d = win_q;
      for (int r = 0; r < MATRIX_SIZE; r++) begin
         for (int c = 0; c < MATRIX_SIZE - 1; c++) begin
            win_d[win_idx(r, c, MATRIX_SIZE)] = win_q[win_idx(r, c + 1, MATRIX_SIZE)];
         end
         win_d[win_idx(r, MATRIX_SIZE - 1, MATRIX_SIZE)] = tap[MATRIX_SIZE-1-r];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         win_q <= win_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         out_matrix_q <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         frame_done_q <= 1'b0;
         if (accept && win_pos) begin
            out_matrix_q <= win_d;
            out_valid_q  <= 1'b1;
            frame_done_q <= last_pos;
         end else if (out_ready) begin
            out_valid_q  <= 1'b0;
         end
      end
   end

   assign out_matrix = out_matrix_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_window_gen : scoreboard bench for conv_window_gen on a 5x4 frame.|
// |                                                             Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_conv_window_gen;

   localparam int W    = 8;
   localparam int COLS = 5;
   localparam int ROWS = 4;
   localparam int MW   = 9 * W;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [W-1:0]  in_pixel  = '0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [MW-1:0] out_matrix;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          frame_done;
`ifdef CONV_WINDOW_SOF_EN
   logic          in_sof    = 1'b0;
`endif

   typedef struct {
      logic [MW-1:0] m;
      logic          fd;
      int            base;
      int            idx;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks       = 0;
   int   errors       = 0;
   int   windows_seen = 0;
   int   frame_wins   = 0;
   bit   stall_armed  = 1'b0;
   bit   sof_first    = 1'b0;

   int            br_tab [6] = '{12, 13, 14, 17, 18, 19};
   logic [MW-1:0] first0   = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
   logic [MW-1:0] first100 = {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100};

   always #5 clk = ~clk;

   conv_window_gen #(
      .IMAGE_WIDTH (W),
      .MATRIX_SIZE (3),
      .IMG_COLS    (COLS),
      .IMG_ROWS    (ROWS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_pixel   (in_pixel),
      .in_valid   (in_valid),
`ifdef CONV_WINDOW_SOF_EN
      .in_sof     (in_sof),
`endif
      .in_ready   (in_ready),
      .out_matrix (out_matrix),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [MW-1:0] win_exp(input int base, input int r, input int c);
      logic [MW-1:0] m;
      m = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            m[(rr*3+cc)*W +: W] = W'(base + (r - 2 + rr) * COLS + (c - 2 + cc));
      return m;
   endfunction

   // Present one pixel and hold it until accepted; queue the window it should produce.
   task automatic send(input int pix, input int base, input int r, input int c,
                       input bit want, input int stall_idx);
      int   n;
      exp_t e;
      n        = 0;
      in_pixel = W'(pix);
      in_valid = 1'b1;
      @(negedge clk); #1;
      while (!in_ready) begin
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: actual in_ready 0 required 1 within 50 cycles");
            return;
         end
         @(negedge clk); #1;
      end
      @(posedge clk);
      if (want && r >= 2 && c >= 2) begin
         e.m    = win_exp(base, r, c);
         e.fd   = (r == ROWS - 1) && (c == COLS - 1);
         e.base = base;
         e.idx  = (r - 2) * (COLS - 2) + (c - 2);
         sb.push_back(e);
         if (e.idx == stall_idx) stall_armed = 1'b1;
      end
      #1;
   endtask

   task automatic send_frame(input int base, input int stall_idx);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
`ifdef CONV_WINDOW_SOF_EN
            in_sof = (r == 0 && c == 0) ? sof_first : 1'b0;
`endif
            send(base + r * COLS + c, base, r, c, 1'b1, stall_idx);
         end
      end
`ifdef CONV_WINDOW_SOF_EN
      in_sof = 1'b0;
`endif
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check("drain_empty", MW'(sb.size()), '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"},  MW'(out_valid),  '0);
      check({tag, "_frame_done"}, MW'(frame_done), '0);
      check({tag, "_out_matrix"}, out_matrix,      '0);
      check({tag, "_in_ready"},   MW'(in_ready),   MW'(1));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) check("frame_done_with_valid", MW'(out_valid), MW'(1));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window: actual %h required none", out_matrix);
            end else begin
               mon_e = sb.pop_front();
               windows_seen++;
               frame_wins++;
               check("window", out_matrix, mon_e.m);
               check("frame_done", MW'(frame_done), MW'(mon_e.fd));
               check("bottom_right", MW'(out_matrix[8*W +: W]), MW'(mon_e.base + br_tab[mon_e.idx]));
               if (mon_e.idx == 0 && mon_e.base == 0)   check("first_window_f0", out_matrix, first0);
               if (mon_e.idx == 0 && mon_e.base == 100) check("first_window_f100", out_matrix, first100);
               if (mon_e.fd) begin
                  check("windows_per_frame", MW'(frame_wins), MW'(6));
                  frame_wins = 0;
               end
            end
         end
      end
   end

   // Back-pressure: hold out_ready low for four cycles once the armed window appears.
   initial begin : stall_proc
      logic [MW-1:0] held;
      forever begin
         @(posedge clk); #2;
         if (stall_armed && out_valid) begin
            stall_armed = 1'b0;
            out_ready   = 1'b0;
            held        = out_matrix;
            repeat (4) begin
               @(negedge clk);
               check("stall_in_ready",  MW'(in_ready),  '0);
               check("stall_out_valid", MW'(out_valid), MW'(1));
               check("stall_hold",      out_matrix,     held);
            end
            @(posedge clk); #2;
            out_ready = 1'b1;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

`ifdef CONV_WINDOW_SOF_EN
      for (int j = 0; j < 7; j++) send(j * 37 + 3, 0, 0, 0, 1'b0, -1);
      sof_first = 1'b1;
`endif
      send_frame(0, -1);
      sof_first = 1'b0;
      send_frame(100, -1);
      send_frame(200, 2);
      in_valid = 1'b0;
      drain();

      for (int p = 0; p < 9; p++) send(p, 0, p / COLS, p % COLS, 1'b0, -1);
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      @(posedge clk); #1;
      check_reset_outputs("midframe_reset_hold");
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_frame(0, -1);
      in_valid = 1'b0;
      drain();
      check("total_windows", MW'(windows_seen), MW'(24));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
